// File: rtl/prog_timer.sv
// ---------------------------------------------------------------------------
// prog_timer: parametrised down-counting timer with run-time load value,
// one-shot / auto-reload modes, pause-on-disable, a sticky done flag and an
// optional tick prescaler.
//
// Optional feature macro: PRESCALER_EN
//   defined   -> a tick occurs once every prescale_i+1 enabled RUN cycles
//   undefined -> a tick occurs every enabled RUN cycle; prescale_i is ignored
//
// Ports
//   clock_i     rising-edge clock
//   reset_i     synchronous active-high reset
//   en_i        count enable; low pauses the countdown
//   load_i      strobe: capture t_load_i/mode_i and (re)start the timer
//   t_load_i    start/reload value; 0 selects T_DEFAULT
//   mode_i      0 = one-shot, 1 = auto-reload (captured on load)
//   clear_i     abort back to idle
//   prescale_i  tick divider (PRESCALER_EN only)
//   count_o     remaining ticks
//   pass_o      one-cycle pulse on each expiry
//   done_o      sticky one-shot expiry flag
//   busy_o      high while running or paused (combinational from state)
// ---------------------------------------------------------------------------
module prog_timer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned T_DEFAULT = 5,
    parameter int unsigned PS_W      = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] t_load_i,
    input  logic             mode_i,
    input  logic             clear_i,
    input  logic [PS_W-1:0]  prescale_i,
    output logic [WIDTH-1:0] count_o,
    output logic             pass_o,
    output logic             done_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] load_val;
    logic             run_cyc;
    logic             tick;

    // An enabled cycle spent in RUN; the pause edge itself never ticks.
    assign run_cyc = (state_q == ST_RUN) && en_i;

`ifdef PRESCALER_EN
    logic [PS_W-1:0] ps_q, ps_d;

    // >= keeps the divider bounded if prescale_i is lowered mid-period.
    assign tick = run_cyc && (ps_q >= prescale_i);

    // Prescaler: restarts on load/clear, frozen whenever not counting.
    always_comb begin
        ps_d = ps_q;
        if (clear_i || load_i) begin
            ps_d = '0;
        end else if (run_cyc) begin
            ps_d = tick ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    logic unused_prescale;

    assign tick            = run_cyc;
    assign unused_prescale = ^prescale_i;
`endif

    // Next-state logic: clear > load > tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        pass_d   = 1'b0;
        done_d   = done_q;
        load_val = (t_load_i == '0) ? WIDTH'(T_DEFAULT) : t_load_i;

        if (clear_i) begin
            state_d = ST_IDLE;
            count_d = '0;
            done_d  = 1'b0;
        end else if (load_i) begin
            reload_d = load_val;
            count_d  = load_val;
            mode_d   = mode_i;
            done_d   = 1'b0;
            state_d  = en_i ? ST_RUN : ST_HOLD;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!en_i) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        if (count_q == WIDTH'(1)) begin
                            pass_d = 1'b1;
                            if (mode_q) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                done_d  = 1'b1;
                                state_d = ST_DONE;
                            end
                        end else if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Resume edge only changes state; counting restarts next edge.
                    if (en_i) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= WIDTH'(T_DEFAULT);
            mode_q   <= 1'b0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
        end
    end

    assign count_o = count_q;
    assign pass_o  = pass_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_prog_timer.sv
// ---------------------------------------------------------------------------
// tb_prog_timer: self-checking bench for prog_timer (WIDTH=4, T_DEFAULT=5).
// Directed scenarios use hand-derived expected sequences; a randomized phase
// is checked against a behavioural model of the timer rules.
// ---------------------------------------------------------------------------
module tb_prog_timer;

    localparam int unsigned W   = 4;
    localparam int unsigned TD  = 5;
    localparam int unsigned PSW = 4;

    logic           clk;
    logic           reset_i;
    logic           en_i;
    logic           load_i;
    logic [W-1:0]   t_load_i;
    logic           mode_i;
    logic           clear_i;
    logic [PSW-1:0] prescale_i;
    logic [W-1:0]   count_o;
    logic           pass_o;
    logic           done_o;
    logic           busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the timer rules.
    int m_count  = 0;
    int m_reload = TD;
    bit m_mode   = 1'b0;
    bit m_busy   = 1'b0;
    bit m_run    = 1'b0;
    bit m_done   = 1'b0;
    bit m_pass   = 1'b0;
    int m_ps     = 0;

    prog_timer #(
        .WIDTH    (W),
        .T_DEFAULT(TD),
        .PS_W     (PSW)
    ) dut (
        .clock_i   (clk),
        .reset_i   (reset_i),
        .en_i      (en_i),
        .load_i    (load_i),
        .t_load_i  (t_load_i),
        .mode_i    (mode_i),
        .clear_i   (clear_i),
        .prescale_i(prescale_i),
        .count_o   (count_o),
        .pass_o    (pass_o),
        .done_o    (done_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        bit tick;
        if (reset_i) begin
            m_count = 0; m_reload = TD; m_mode = 0; m_busy = 0; m_run = 0;
            m_done = 0; m_pass = 0; m_ps = 0;
        end else if (clear_i) begin
            m_count = 0; m_busy = 0; m_run = 0; m_done = 0; m_pass = 0; m_ps = 0;
        end else if (load_i) begin
            m_reload = (t_load_i == 0) ? TD : int'(t_load_i);
            m_count  = m_reload;
            m_mode   = mode_i;
            m_done   = 0;
            m_pass   = 0;
            m_ps     = 0;
            m_busy   = 1;
            m_run    = en_i;
        end else begin
            m_pass = 0;
            if (m_busy) begin
                tick = 0;
                if (m_run && en_i) begin
`ifdef PRESCALER_EN
                    if (m_ps >= int'(prescale_i)) begin
                        tick = 1; m_ps = 0;
                    end else begin
                        m_ps = m_ps + 1;
                    end
`else
                    tick = 1;
`endif
                end
                if (tick) begin
                    if (m_count == 1) begin
                        m_pass = 1;
                        if (m_mode) begin
                            m_count = m_reload;
                        end else begin
                            m_count = 0; m_done = 1; m_busy = 0;
                        end
                    end else begin
                        m_count = m_count - 1;
                    end
                end
                m_run = m_busy && en_i;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset_i = 0; en_i = 1; load_i = 0; t_load_i = '0;
        mode_i = 0; clear_i = 0; prescale_i = '0;
    endtask

    task automatic test_reset();
        logic [6:0] got, exp;
        idle_inputs();
        reset_i = 1;
        step();
        reset_i = 0;
        got = {count_o, pass_o, done_o, busy_o};
        exp = {4'd0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) $display("FAIL reset: got cnt=%0d p=%b d=%b b=%b want cnt=%0d p=%b d=%b b=%b",
                                  got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        else n_pass++;
    endtask

    task automatic test_one_shot();
        logic [6:0] got, exp;
        idle_inputs();
        load_i = 1; t_load_i = 4'd0; mode_i = 0;
        step();
        load_i = 0;
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) step();
            got = {count_o, pass_o, done_o, busy_o};
            exp = {4'((i >= 5) ? 0 : 5 - i), 1'(i == 5), 1'(i >= 5), 1'(i < 5)};
            n_checks++;
            if (got !== exp) $display("FAIL one_shot e%0d: got cnt=%0d p=%b d=%b b=%b want cnt=%0d p=%b d=%b b=%b",
                                      i, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
            else n_pass++;
        end
        clear_i = 1;
        step();
        clear_i = 0;
        n_checks++;
        if ({done_o, busy_o, count_o} !== 6'd0)
            $display("FAIL done_clear: got d=%b b=%b cnt=%0d want 0 0 0", done_o, busy_o, count_o);
        else n_pass++;
    endtask

    task automatic test_auto_reload();
        logic [6:0] got, exp;
        idle_inputs();
        load_i = 1; t_load_i = 4'd3; mode_i = 1;
        step();
        load_i = 0; mode_i = 0;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) step();
            got = {count_o, pass_o, done_o, busy_o};
            exp = {4'(3 - (i % 3)), 1'((i > 0) && (i % 3 == 0)), 1'b0, 1'b1};
            n_checks++;
            if (got !== exp) $display("FAIL auto_reload e%0d: got cnt=%0d p=%b d=%b b=%b want cnt=%0d p=%b d=%b b=%b",
                                      i, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
            else n_pass++;
        end
        clear_i = 1;
        step();
        clear_i = 0;
    endtask

    task automatic test_pause();
        // en per edge after the load edge; resume edge does not decrement.
        bit         en_pat [9]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        int         exp_cnt [9] = '{4, 3, 3, 3, 3, 3, 2, 1, 0};
        logic [6:0] got, exp;
        idle_inputs();
        load_i = 1; t_load_i = 4'd5;
        step();
        load_i = 0;
        for (int i = 0; i < 9; i++) begin
            en_i = en_pat[i];
            step();
            got = {count_o, pass_o, done_o, busy_o};
            exp = {4'(exp_cnt[i]), 1'(i == 8), 1'(i == 8), 1'(i != 8)};
            n_checks++;
            if (got !== exp) $display("FAIL pause e%0d: got cnt=%0d p=%b d=%b b=%b want cnt=%0d p=%b d=%b b=%b",
                                      i + 1, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
            else n_pass++;
        end
        en_i = 1;
    endtask

    task automatic test_load_override();
        logic [6:0] got, exp;
        idle_inputs();
        load_i = 1; t_load_i = 4'd4;
        step();
        load_i = 0;
        step(); step(); step();
        n_checks++;
        if (count_o !== 4'd1) $display("FAIL override_pre: got cnt=%0d want cnt=1", count_o);
        else n_pass++;
        load_i = 1; t_load_i = 4'd4;
        step();
        got = {count_o, pass_o, done_o, busy_o};
        exp = {4'd4, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (got !== exp) $display("FAIL load_over_expiry: got cnt=%0d p=%b d=%b b=%b want cnt=%0d p=%b d=%b b=%b",
                                  got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        else n_pass++;
        clear_i = 1;
        step();
        clear_i = 0; load_i = 0;
        step();
        got = {count_o, pass_o, done_o, busy_o};
        exp = 7'd0;
        n_checks++;
        if (got !== exp) $display("FAIL clear_wins_load: got cnt=%0d p=%b d=%b b=%b want cnt=0 p=0 d=0 b=0",
                                  got[6:3], got[2], got[1], got[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [6:0] got;
        idle_inputs();
        load_i = 1; t_load_i = 4'd4;
        step();
        load_i = 0;
        step(); step();
        n_checks++;
        if (count_o !== 4'd2) $display("FAIL reset_mid_pre: got cnt=%0d want cnt=2", count_o);
        else n_pass++;
        reset_i = 1;
        step();
        reset_i = 0;
        got = {count_o, pass_o, done_o, busy_o};
        n_checks++;
        if (got !== 7'd0) $display("FAIL reset_mid: got cnt=%0d p=%b d=%b b=%b want cnt=0 p=0 d=0 b=0",
                                   got[6:3], got[2], got[1], got[0]);
        else n_pass++;
    endtask

    task automatic test_hold_load();
        logic [6:0] got, exp;
        idle_inputs();
        en_i = 0; load_i = 1; t_load_i = 4'd15;
        step();
        load_i = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) en_i = 1;
            if (i > 0) step();
            got = {count_o, pass_o, done_o, busy_o};
            // frozen while paused and on the resume edge (i==3)
            exp = {4'((i >= 4) ? 14 : 15), 1'b0, 1'b0, 1'b1};
            n_checks++;
            if (got !== exp) $display("FAIL hold_load e%0d: got cnt=%0d p=%b d=%b b=%b want cnt=%0d p=%b d=%b b=%b",
                                      i, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
            else n_pass++;
        end
        clear_i = 1;
        step();
        clear_i = 0;
    endtask

`ifdef PRESCALER_EN
    task automatic test_prescaler();
        logic [6:0] got, exp;
        idle_inputs();
        prescale_i = 4'd2;
        load_i = 1; t_load_i = 4'd2;
        step();
        load_i = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            got = {count_o, pass_o, done_o, busy_o};
            exp = {4'(2 - i / 3), 1'(i == 6), 1'(i == 6), 1'(i < 6)};
            n_checks++;
            if (got !== exp) $display("FAIL prescaler e%0d: got cnt=%0d p=%b d=%b b=%b want cnt=%0d p=%b d=%b b=%b",
                                      i, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
            else n_pass++;
        end
        prescale_i = '0;
    endtask
`endif

    task automatic test_random();
        logic [6:0] got, exp;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            reset_i    = ($urandom_range(0, 99) == 0);
            clear_i    = ($urandom_range(0, 29) == 0);
            load_i     = ($urandom_range(0, 7) == 0);
            t_load_i   = W'($urandom_range(0, 5));
            mode_i     = 1'($urandom_range(0, 1));
            en_i       = ($urandom_range(0, 3) != 0);
            prescale_i = PSW'($urandom_range(0, 2));
            step();
            got = {count_o, pass_o, done_o, busy_o};
            exp = {4'(m_count), m_pass, m_done, m_busy};
            n_checks++;
            if (got !== exp) $display("FAIL random c%0d: got cnt=%0d p=%b d=%b b=%b want cnt=%0d p=%b d=%b b=%b",
                                      i, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
            else n_pass++;
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_load_override();
        test_reset_mid();
        test_hold_load();
`ifdef PRESCALER_EN
        test_prescaler();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
